max_pcx_unpacker: RTL and testbench

- Host-side end of the Maxeler PCX word stream: pulls 32-bit words from the core's PCX output FIFO via max_pcx_read / max_pcx_empty / max_pcx_almost_empty / max_pcx_data.
- Reassembles each group of 4 words into one 124-bit PCX packet.
- Presents each packet on a valid/ready output toward the host-side CCX model.
- Sits between the opensparc_t1 PCX FIFO and the host L2/CCX emulation logic.

---
 rtl/max_pcx_unpacker_if.sv | 28 ++
 rtl/max_pcx_unpacker.sv | 112 +++++++++++
 tb/tb_max_pcx_unpacker.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/max_pcx_unpacker_if.sv
// PCX unpacker bus: FIFO read side plus the packet valid/ready output
// and the status counters. The slave modport belongs to the unpacker;
// the master modport is the FIFO/host side.
interface max_pcx_unpacker_if #(
  parameter int PKT_W = 124,
  parameter int CNT_W = 16
);
  logic             max_pcx_empty;
  logic             max_pcx_almost_empty;
  logic [31:0]      max_pcx_data;
  logic             max_pcx_read;
  logic [PKT_W-1:0] pcx_pkt;
  logic             pcx_pkt_vld;
  logic             pcx_pkt_rdy;
  logic [CNT_W-1:0] pkt_count;
  logic [CNT_W-1:0] drop_count;
  logic             fmt_err;

  modport slave (
    input  max_pcx_empty, max_pcx_almost_empty, max_pcx_data, pcx_pkt_rdy,
    output max_pcx_read, pcx_pkt, pcx_pkt_vld, pkt_count, drop_count, fmt_err
  );

  modport master (
    output max_pcx_empty, max_pcx_almost_empty, max_pcx_data, pcx_pkt_rdy,
    input  max_pcx_read, pcx_pkt, pcx_pkt_vld, pkt_count, drop_count, fmt_err
  );
endinterface

// File: rtl/max_pcx_unpacker.sv
// Pulls 32-bit words from the PCX FIFO, reassembles each group of WORDS
// words into one PKT_W-bit packet and offers it on a valid/ready output.
// Packets whose top (valid) bit is clear are counted and discarded.
module max_pcx_unpacker #(
  parameter int PKT_W = 124,
  parameter int WORDS = 4,
  parameter int CNT_W = 16
) (
  input logic                gclk,
  input logic                arst_l,
  max_pcx_unpacker_if.slave  bus
);
  localparam int WC_W   = $clog2(WORDS);
  // word 0 carries only the top slice of the packet; its upper bits must be 0
  localparam int HEAD_W = PKT_W - 32 * (WORDS - 1);

  typedef enum logic {ST_ASSEMBLE, ST_HOLD} state_t;

  state_t           r_state;
  logic             r_en;        // blocks reads during the first cycle out of reset
  logic             r_rd_vld;    // a read was accepted last cycle, data is on the bus now
  logic             r_guard;     // last read took the final word; flags may be stale
  logic [WC_W-1:0]  r_word_cnt;
  logic [PKT_W-1:0] r_asm;
  logic [PKT_W-1:0] r_pkt;
  logic             r_vld;
  logic             r_fmt_err;
  logic [CNT_W-1:0] r_pkt_cnt;
  logic [CNT_W-1:0] r_drop_cnt;

  logic             w_room;
  logic             w_read;
  logic             w_last;
  logic             w_accept;
  logic             w_out_free;
  logic [PKT_W-1:0] w_full;

  // words received plus the one in flight must leave room in the packet
  assign w_room     = ({1'b0, r_word_cnt} + {{WC_W{1'b0}}, r_rd_vld}) < (WC_W+1)'(WORDS);
  assign w_read     = r_en & ~bus.max_pcx_empty & ~r_guard & (r_state == ST_ASSEMBLE) & w_room;
  assign w_last     = r_rd_vld & (r_word_cnt == WC_W'(WORDS - 1));
  assign w_accept   = r_vld & bus.pcx_pkt_rdy;
  assign w_out_free = ~r_vld | bus.pcx_pkt_rdy;
  // completed packet as it looks in the cycle the final word arrives
  assign w_full     = {r_asm[PKT_W-1:32], bus.max_pcx_data};

  assign bus.max_pcx_read = w_read;
  assign bus.pcx_pkt      = r_pkt;
  assign bus.pcx_pkt_vld  = r_vld;
  assign bus.pkt_count    = r_pkt_cnt;
  assign bus.drop_count   = r_drop_cnt;
  assign bus.fmt_err      = r_fmt_err;

  // assembly FSM, FIFO read pipeline, output register and counters
  always_ff @(posedge gclk or negedge arst_l) begin
    if (!arst_l) begin
      r_state    <= ST_ASSEMBLE;
      r_en       <= 1'b0;
      r_rd_vld   <= 1'b0;
      r_guard    <= 1'b0;
      r_word_cnt <= '0;
      r_asm      <= '0;
      r_pkt      <= '0;
      r_vld      <= 1'b0;
      r_fmt_err  <= 1'b0;
      r_pkt_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_en     <= 1'b1;
      r_rd_vld <= w_read;
      r_guard  <= w_read & bus.max_pcx_almost_empty;
      // consumed output empties unless a new packet lands below
      if (w_accept) r_vld <= 1'b0;
      case (r_state)
        ST_ASSEMBLE: begin
          if (r_rd_vld) begin
            if (r_word_cnt == '0) begin
              r_asm[PKT_W-1 -: HEAD_W] <= bus.max_pcx_data[HEAD_W-1:0];
              if (|bus.max_pcx_data[31:HEAD_W]) r_fmt_err <= 1'b1;
            end
            for (int k = 1; k < WORDS; k++) begin
              if (r_word_cnt == WC_W'(k)) r_asm[(WORDS-1-k)*32 +: 32] <= bus.max_pcx_data;
            end
            if (w_last) begin
              r_word_cnt <= '0;
              if (!w_full[PKT_W-1]) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
              end else if (w_out_free) begin
                r_pkt     <= w_full;
                r_vld     <= 1'b1;
                r_pkt_cnt <= r_pkt_cnt + 1'b1;
              end else begin
                r_state <= ST_HOLD;
              end
            end else begin
              r_word_cnt <= r_word_cnt + 1'b1;
            end
          end
        end
        ST_HOLD: begin
          // held packet moves up in the same cycle the old one is taken
          if (w_accept) begin
            r_pkt     <= r_asm;
            r_vld     <= 1'b1;
            r_pkt_cnt <= r_pkt_cnt + 1'b1;
            r_state   <= ST_ASSEMBLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_max_pcx_unpacker.sv
// Directed bench for max_pcx_unpacker: a queue-backed FIFO model with
// one-cycle read latency, a packet collector, and hand-computed packets.
module tb_max_pcx_unpacker;
  logic gclk   = 1'b0;
  logic arst_l = 1'b0;
  always #5 gclk = ~gclk;

  max_pcx_unpacker_if #(.PKT_W(124), .CNT_W(16)) bus();
  max_pcx_unpacker #(.PKT_W(124), .WORDS(4), .CNT_W(16)) dut (
    .gclk  (gclk),
    .arst_l(arst_l),
    .bus   (bus)
  );

  int           n_tests = 0;
  int           n_fail  = 0;
  logic [31:0]  q[$];
  logic [123:0] got[$];
  logic         s_rd, s_empty;
  logic         prev_guard = 1'b0;
  int           rd_cycles, rd_first, rd_last, cyc;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_flags();
    bus.max_pcx_empty        = (q.size() == 0);
    bus.max_pcx_almost_empty = (q.size() == 1);
  endtask

  task automatic push4(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [31:0] d);
    q.push_back(a); q.push_back(b); q.push_back(c); q.push_back(d);
    set_flags();
  endtask

  // one clock: sample before the edge, update FIFO model and collector after it
  task automatic tick();
    logic         ae, vld;
    logic [123:0] pkt;
    @(negedge gclk);
    s_rd    = bus.max_pcx_read;
    s_empty = bus.max_pcx_empty;
    ae      = bus.max_pcx_almost_empty;
    vld     = bus.pcx_pkt_vld;
    pkt     = bus.pcx_pkt;
    chk("rd_while_empty", 128'(s_rd & s_empty), 128'(0));
    chk("rd_after_last_word", 128'(prev_guard & s_rd), 128'(0));
    if (s_rd) begin
      rd_cycles++;
      if (rd_first < 0) rd_first = cyc;
      rd_last = cyc;
    end
    @(posedge gclk);
    #1;
    cyc++;
    if (s_rd && q.size() > 0) bus.max_pcx_data = q.pop_front();
    if (vld && bus.pcx_pkt_rdy && arst_l) got.push_back(pkt);
    prev_guard = s_rd & ae;
    set_flags();
  endtask

  task automatic wait_got(input int n, input int budget, input string tag);
    int i = 0;
    while (got.size() < n && i < budget) begin
      tick();
      i++;
    end
    chk(tag, 128'(got.size() >= n), 128'(1));
  endtask

  initial begin
    bus.pcx_pkt_rdy  = 1'b1;
    bus.max_pcx_data = 32'h0;
    rd_cycles = 0; rd_first = -1; rd_last = 0; cyc = 0;
    set_flags();

    // reset: words waiting in the FIFO must not be read yet
    push4(32'h0A000001, 32'h11111111, 32'h22222222, 32'h33333333);
    repeat (3) tick();
    #1;
    chk("rst_read",  128'(s_rd),                 128'(0));
    chk("rst_vld",   128'(bus.pcx_pkt_vld),      128'(0));
    chk("rst_pkt",   128'(bus.pcx_pkt),          128'(0));
    chk("rst_pcnt",  128'(bus.pkt_count),        128'(0));
    chk("rst_dcnt",  128'(bus.drop_count),       128'(0));
    chk("rst_fmt",   128'(bus.fmt_err),          128'(0));
    chk("rst_qsize", 128'(q.size()),             128'(4));

    // basic packet, four back-to-back reads
    @(negedge gclk) arst_l = 1'b1;
    rd_cycles = 0; rd_first = -1;
    wait_got(1, 20, "t1_timeout");
    chk("t1_rd_count",  128'(rd_cycles),          128'(4));
    chk("t1_rd_consec", 128'(rd_last - rd_first), 128'(3));
    chk("t1_pkt",       128'(got[0]), 128'(124'hA000001_11111111_22222222_33333333));
    chk("t1_pcnt",      128'(bus.pkt_count),      128'(1));
    chk("t1_fmt",       128'(bus.fmt_err),        128'(0));
    tick();
    #1;
    chk("t1_vld_drop",  128'(bus.pcx_pkt_vld),    128'(0));

    // backpressure: first packet in output, second in HOLD, third left in FIFO
    bus.pcx_pkt_rdy = 1'b0;
    push4(32'h0B00000A, 32'hAAAA0001, 32'hAAAA0002, 32'hAAAA0003);
    push4(32'h0C00000B, 32'hBBBB0001, 32'hBBBB0002, 32'hBBBB0003);
    push4(32'h0D00000C, 32'hCCCC0001, 32'hCCCC0002, 32'hCCCC0003);
    repeat (30) tick();
    #1;
    chk("t2_vld",     128'(bus.pcx_pkt_vld),  128'(1));
    chk("t2_outpkt",  128'(bus.pcx_pkt), 128'(124'hB00000A_AAAA0001_AAAA0002_AAAA0003));
    chk("t2_qleft",   128'(q.size()),         128'(4));
    chk("t2_noread",  128'(bus.max_pcx_read), 128'(0));
    chk("t2_pcnt",    128'(bus.pkt_count),    128'(2));
    bus.pcx_pkt_rdy = 1'b1;
    wait_got(4, 40, "t2_timeout");
    chk("t2_pkt_a",   128'(got[1]), 128'(124'hB00000A_AAAA0001_AAAA0002_AAAA0003));
    chk("t2_pkt_b",   128'(got[2]), 128'(124'hC00000B_BBBB0001_BBBB0002_BBBB0003));
    chk("t2_pkt_c",   128'(got[3]), 128'(124'hD00000C_CCCC0001_CCCC0002_CCCC0003));
    chk("t2_pcnt3",   128'(bus.pkt_count),    128'(4));
    chk("t2_qempty",  128'(q.size()),         128'(0));

    // drain to the last word, refill at once: no read right after the last-word read
    q.push_back(32'h08000D0D); q.push_back(32'hDDDD0001); q.push_back(32'hDDDD0002);
    set_flags();
    for (int i = 0; i < 20 && q.size() > 0; i++) tick();
    q.push_back(32'hDDDD0003);
    set_flags();
    tick();
    chk("t3_not_empty", 128'(s_empty), 128'(0));
    chk("t3_guard_rd",  128'(s_rd),    128'(0));
    wait_got(5, 20, "t3_timeout");
    chk("t3_pkt",  128'(got[4]), 128'(124'h8000D0D_DDDD0001_DDDD0002_DDDD0003));
    chk("t3_pcnt", 128'(bus.pkt_count), 128'(5));

    // invalid packet dropped, following one delivered
    push4(32'h00000001, 32'hEEEE0001, 32'hEEEE0002, 32'hEEEE0003);
    push4(32'h0F00000F, 32'hFFFF0001, 32'hFFFF0002, 32'hFFFF0003);
    wait_got(6, 30, "t4_timeout");
    repeat (2) tick();
    chk("t4_ngot", 128'(got.size()),     128'(6));
    chk("t4_pkt",  128'(got[5]), 128'(124'hF00000F_FFFF0001_FFFF0002_FFFF0003));
    chk("t4_dcnt", 128'(bus.drop_count), 128'(1));
    chk("t4_pcnt", 128'(bus.pkt_count),  128'(6));

    // format error on word 0, sticky across a clean packet
    push4(32'hF8000000, 32'h12345678, 32'h9ABCDEF0, 32'h0BADF00D);
    wait_got(7, 20, "t5_timeout");
    chk("t5_pkt", 128'(got[6]), 128'(124'h8000000_12345678_9ABCDEF0_0BADF00D));
    chk("t5_fmt", 128'(bus.fmt_err), 128'(1));
    push4(32'h08000001, 32'h00000001, 32'h00000002, 32'h00000003);
    wait_got(8, 20, "t5b_timeout");
    chk("t5_pkt2",   128'(got[7]), 128'(124'h8000001_00000001_00000002_00000003));
    chk("t5_sticky", 128'(bus.fmt_err),   128'(1));
    chk("t5_pcnt",   128'(bus.pkt_count), 128'(8));

    // reset mid-packet with a packet sitting in the output register
    bus.pcx_pkt_rdy = 1'b0;
    push4(32'h0800001A, 32'h1A1A1A1A, 32'h2B2B2B2B, 32'h3C3C3C3C);
    q.push_back(32'h0FFFFFFF); q.push_back(32'h44444444); q.push_back(32'h55555555);
    set_flags();
    repeat (20) tick();
    #1;
    chk("t6_vld_pre",  128'(bus.pcx_pkt_vld), 128'(1));
    chk("t6_pkt_pre",  128'(bus.pcx_pkt), 128'(124'h800001A_1A1A1A1A_2B2B2B2B_3C3C3C3C));
    chk("t6_pcnt_pre", 128'(bus.pkt_count),   128'(9));
    chk("t6_q_pre",    128'(q.size()),        128'(0));
    #1 arst_l = 1'b0;
    #1;
    chk("t6_rst_vld",  128'(bus.pcx_pkt_vld),  128'(0));
    chk("t6_rst_pkt",  128'(bus.pcx_pkt),      128'(0));
    chk("t6_rst_pcnt", 128'(bus.pkt_count),    128'(0));
    chk("t6_rst_dcnt", 128'(bus.drop_count),   128'(0));
    chk("t6_rst_fmt",  128'(bus.fmt_err),      128'(0));
    chk("t6_rst_read", 128'(bus.max_pcx_read), 128'(0));
    repeat (2) tick();
    @(negedge gclk) arst_l = 1'b1;
    got.delete();
    prev_guard = 1'b0;
    bus.pcx_pkt_rdy = 1'b1;
    push4(32'h09000123, 32'h66666666, 32'h77777777, 32'h88888888);
    wait_got(1, 20, "t6_timeout");
    chk("t6_pkt",  128'(got[0]), 128'(124'h9000123_66666666_77777777_88888888));
    chk("t6_pcnt", 128'(bus.pkt_count),  128'(1));
    chk("t6_dcnt", 128'(bus.drop_count), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
